// File: rtl/spi_byte_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_receiver_if
// Brief    : SPI pin and received-byte bundle for the SPI byte receiver.
// Revision : 1.0
// ============================================================================
interface spi_byte_receiver_if;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       spi_miso;
    logic [7:0] rx_byte;
    logic       rdy;
    logic       overrun;
    logic       bit_err;
    logic       busy;

    modport slave (
        input  spi_sck, spi_mosi, spi_cs_n,
        output spi_miso, rx_byte, rdy, overrun, bit_err, busy
    );

    modport master (
        output spi_sck, spi_mosi, spi_cs_n,
        input  spi_miso, rx_byte, rdy, overrun, bit_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_receiver
// Brief    : Mode-0 SPI slave; syncs pins into clk, assembles bytes, stretches
//            the byte-ready strobe and echoes the previous byte on MISO.
// Revision : 1.0
// ============================================================================
module spi_byte_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int RDY_HOLD    = 4,
    parameter int TIMEOUT     = 1024,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    spi_byte_receiver_if.slave bus
);
    localparam int c_hold_w = $clog2(RDY_HOLD + 1);
    localparam int c_to_w   = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sck_dly_q, sck_dly_d;
    logic                   cs_dly_q, cs_dly_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             tx_q, tx_d;
    logic                   done_q, done_d;
    logic [7:0]             rx_byte_q, rx_byte_d;
    logic                   rdy_q, rdy_d;
    logic [c_hold_w-1:0]    hold_q, hold_d;
    logic [c_to_w-1:0]      to_q, to_d;
    logic                   overrun_q, overrun_d;
    logic                   bit_err_q, bit_err_d;
    logic                   busy_q, busy_d;
    logic                   miso_q, miso_d;

    logic w_sck_s, w_mosi_s, w_cs_s;
    logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;

    assign w_sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign w_mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign w_cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~sck_dly_q;
    assign w_sck_fall = ~w_sck_s & sck_dly_q;
    assign w_cs_rise  = w_cs_s & ~cs_dly_q;
    assign w_cs_fall  = ~w_cs_s & cs_dly_q;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
        sck_dly_d   = w_sck_s;
        cs_dly_d    = w_cs_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        rx_byte_d   = rx_byte_q;
        rdy_d       = rdy_q;
        hold_d      = hold_q;
        to_d        = to_q;
        overrun_d   = 1'b0;
        bit_err_d   = 1'b0;

        // Byte hand-off runs one cycle after the 8th rise, independent of CS.
        if (done_q) begin
            rx_byte_d = shift_q;
            rdy_d     = 1'b1;
            hold_d    = c_hold_w'(RDY_HOLD);
            overrun_d = rdy_q;
        end else if (rdy_q) begin
            if (hold_q == c_hold_w'(1)) begin
                rdy_d  = 1'b0;
                hold_d = '0;
            end else begin
                hold_d = hold_q - c_hold_w'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                to_d      = '0;
                if (w_cs_fall) begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                if (w_sck_rise) begin
                    shift_d   = MSB_FIRST ? {shift_q[6:0], w_mosi_s} : {w_mosi_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    done_d    = (bit_cnt_q == 3'd7);
                end

                if (w_sck_rise || w_sck_fall) begin
                    to_d = '0;
                end else if (bit_cnt_q != 3'd0) begin
                    if (to_q == c_to_w'(TIMEOUT - 1)) begin
                        to_d      = '0;
                        bit_cnt_d = '0;
                        bit_err_d = 1'b1;
                    end else begin
                        to_d = to_q + c_to_w'(1);
                    end
                end else begin
                    to_d = '0;
                end

                // Between bytes the echo register tracks the last completed byte.
                if (bit_cnt_q == 3'd0) begin
                    tx_d = rx_byte_q;
                end else if (w_sck_fall) begin
                    tx_d = MSB_FIRST ? {tx_q[6:0], 1'b0} : {1'b0, tx_q[7:1]};
                end

                if (w_cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    to_d      = '0;
                    if (bit_cnt_q != 3'd0 && !(w_sck_rise && bit_cnt_q == 3'd7)) begin
                        bit_err_d = 1'b1;
                    end
                end
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        miso_d = busy_d & (MSB_FIRST ? tx_d[7] : tx_d[0]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sck_dly_q   <= 1'b0;
            cs_dly_q    <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            done_q      <= 1'b0;
            rx_byte_q   <= '0;
            rdy_q       <= 1'b0;
            hold_q      <= '0;
            to_q        <= '0;
            overrun_q   <= 1'b0;
            bit_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sck_dly_q   <= sck_dly_d;
            cs_dly_q    <= cs_dly_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
            rx_byte_q   <= rx_byte_d;
            rdy_q       <= rdy_d;
            hold_q      <= hold_d;
            to_q        <= to_d;
            overrun_q   <= overrun_d;
            bit_err_q   <= bit_err_d;
            busy_q      <= busy_d;
            miso_q      <= miso_d;
        end
    end

    assign bus.rx_byte  = rx_byte_q;
    assign bus.rdy      = rdy_q;
    assign bus.overrun  = overrun_q;
    assign bus.bit_err  = bit_err_q;
    assign bus.busy     = busy_q;
    assign bus.spi_miso = miso_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_byte_receiver
// Brief    : Scoreboard bench for spi_byte_receiver (two instances, RDY_HOLD 4/100).
// Revision : 1.0
// ============================================================================
module tb_spi_byte_receiver;
    localparam int SYNC  = 2;
    localparam int HOLD  = 4;
    localparam int HOLD2 = 100;
    localparam int TMO   = 64;

    logic clk = 1'b0;
    logic reset;
    logic sck, mosi, cs_n;
    always #5 clk = ~clk;

    spi_byte_receiver_if if1 ();
    spi_byte_receiver_if if2 ();
    assign if1.spi_sck  = sck;
    assign if1.spi_mosi = mosi;
    assign if1.spi_cs_n = cs_n;
    assign if2.spi_sck  = sck;
    assign if2.spi_mosi = mosi;
    assign if2.spi_cs_n = cs_n;

    spi_byte_receiver #(.SYNC_STAGES(SYNC), .RDY_HOLD(HOLD), .TIMEOUT(TMO), .MSB_FIRST(1'b1))
        u_dut (.clk(clk), .reset(reset), .bus(if1));
    spi_byte_receiver #(.SYNC_STAGES(SYNC), .RDY_HOLD(HOLD2), .TIMEOUT(TMO), .MSB_FIRST(1'b1))
        u_dut_ovr (.clk(clk), .reset(reset), .bus(if2));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each rdy rise and tracks strobe shapes.
    logic rdy_prev = 1'b0, rdy2_prev = 1'b0;
    int   rdy_len = 0, berr_cnt = 0, ovr1_cnt = 0, ovr2_cnt = 0, rise2_cnt = 0, fall2_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            if (if1.rdy && !rdy_prev) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("rx_byte", if1.rx_byte, exp_q.pop_front());
                check("rdy_latency", cyc - last_rise_cyc, SYNC + 2);
                rdy_len = 1;
            end else if (if1.rdy) begin
                rdy_len++;
            end else if (rdy_prev) begin
                check("rdy_len", rdy_len, HOLD);
            end
            if (if1.bit_err) berr_cnt++;
            if (if1.overrun) ovr1_cnt++;
            if (if2.overrun) ovr2_cnt++;
            if (if2.rdy && !rdy2_prev) rise2_cnt++;
            if (!if2.rdy && rdy2_prev) fall2_cnt++;
        end
        rdy_prev  = if1.rdy;
        rdy2_prev = if2.rdy;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input int half, output logic [7:0] rd);
        rd = '0;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            tick(half);
            rd[7-i] = if1.spi_miso;
            sck = 1'b1;
            last_rise_cyc = cyc;
            tick(half);
            sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int half, output logic [7:0] rd);
        exp_q.push_back(b);
        send_bits(b, 8, half, rd);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, prev;
        logic [7:0] frame [0:7];
        int b0, o0, r0, f0, t0, d;
        bit seen;

        frame[0] = 8'h55; frame[1] = 8'hFF; frame[2] = 8'h10; frame[3] = 8'h20;
        frame[4] = 8'h30; frame[5] = 8'h40; frame[6] = 8'h50; frame[7] = 8'h01;

        // Reset with toggling pins
        reset = 1'b0; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sck = ~sck; mosi = ~mosi; cs_n = ~cs_n;
        end
        tick(1);
        check("rst_rx_byte", if1.rx_byte, 8'h00);
        check("rst_rdy", if1.rdy, 1'b0);
        check("rst_overrun", if1.overrun, 1'b0);
        check("rst_bit_err", if1.bit_err, 1'b0);
        check("rst_busy", if1.busy, 1'b0);
        check("rst_miso", if1.spi_miso, 1'b0);
        check("rst_busy2", if2.busy, 1'b0);
        sck = 1'b0; mosi = 1'b0; cs_n = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(5);

        // Single byte 0xA5
        cs_n = 1'b0;
        tick(8);
        check("busy_selected", if1.busy, 1'b1);
        send_byte(8'hA5, 8, rd);
        check("miso_first_frame", rd, 8'h00);
        tick(8);
        check("rx_byte_a5", if1.rx_byte, 8'hA5);
        cs_n = 1'b1;
        tick(10);
        check("busy_idle", if1.busy, 1'b0);
        check("miso_idle", if1.spi_miso, 1'b0);
        prev = 8'hA5;

        // Eight-byte frame with read-back
        cs_n = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            send_byte(frame[i], 6, rd);
            check("miso_echo", rd, prev);
            prev = frame[i];
        end
        tick(8);
        cs_n = 1'b1;
        tick(10);

        // Five bits then CS rise
        b0 = berr_cnt;
        cs_n = 1'b0;
        tick(8);
        send_bits(8'hF0, 5, 6, rd);
        tick(2);
        cs_n = 1'b1;
        tick(10);
        check("cs_abort_berr", berr_cnt - b0, 1);
        check("cs_abort_rx_kept", if1.rx_byte, prev);
        cs_n = 1'b0;
        tick(8);
        send_byte(8'h3C, 6, rd);
        check("miso_after_abort", rd, prev);
        prev = 8'h3C;
        tick(8);
        cs_n = 1'b1;
        tick(10);

        // Three bits then SCK stall
        b0 = berr_cnt;
        cs_n = 1'b0;
        tick(8);
        send_bits(8'hAA, 3, 6, rd);
        t0 = cyc;
        seen = 1'b0;
        d = 0;
        for (int i = 0; i < TMO + 40 && !seen; i++) begin
            tick(1);
            if (if1.bit_err) begin
                seen = 1'b1;
                d = cyc - t0;
            end
        end
        check("timeout_seen", seen, 1'b1);
        check("timeout_window", 32'(d >= TMO && d <= TMO + SYNC + 2), 32'd1);
        tick(5);
        check("timeout_berr_once", berr_cnt - b0, 1);
        check("timeout_stays_busy", if1.busy, 1'b1);
        send_byte(8'hC3, 6, rd);
        check("miso_after_timeout", rd, prev);
        prev = 8'hC3;
        tick(8);
        cs_n = 1'b1;
        tick(120);

        // Back-to-back bytes into the long-hold instance
        o0 = ovr2_cnt; r0 = rise2_cnt; f0 = fall2_cnt;
        cs_n = 1'b0;
        tick(8);
        send_byte(8'h12, 5, rd);
        check("miso_before_12", rd, prev);
        send_byte(8'h34, 5, rd);
        check("miso_second_byte", rd, 8'h12);
        tick(8);
        check("ovr_pulse", ovr2_cnt - o0, 1);
        check("ovr_rdy_rise", rise2_cnt - r0, 1);
        check("ovr_rdy_no_gap", fall2_cnt - f0, 0);
        check("ovr_rdy_high", if2.rdy, 1'b1);
        check("ovr_rx_byte", if2.rx_byte, 8'h34);
        cs_n = 1'b1;
        tick(10);

        check("sb_drained", exp_q.size(), 0);
        check("dut1_no_overrun", ovr1_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
